// File: rtl/twi_pkg.sv
// Shared types and constants for the TWI responder: FSM state encoding, ACK/NACK levels, byte width.
package twi_pkg;
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WRITE,
    ST_WRITE_ACK,
    ST_READ,
    ST_MACK
  } twi_state_e;

  localparam logic ACK    = 1'b0;
  localparam logic NACK   = 1'b1;
  localparam int   BYTE_W = 8;
endpackage

// File: rtl/twi_line_filter.sv
// 2-FF synchronizer plus run-length filter for one TWI line; level changes after FILTER_LEN equal samples.
// Latency 2 + FILTER_LEN cycles; rise_o/fall_o pulse in the cycle the new level appears on level_o.
module twi_line_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic line_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);
  logic       meta_q, sync_q, filt_q, rise_q, fall_q;
  logic [3:0] run_q;
  logic       flip;

  // run_q counts consecutive samples that disagree with the filtered level
  assign flip = (sync_q != filt_q) && (run_q == 4'(FILTER_LEN - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      filt_q <= 1'b1;
      run_q  <= '0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      meta_q <= line_i;
      sync_q <= meta_q;
      rise_q <= flip & sync_q;
      fall_q <= flip & ~sync_q;
      if (flip) begin
        filt_q <= sync_q;
        run_q  <= '0;
      end else if (sync_q != filt_q) begin
        run_q <= run_q + 4'd1;
      end else begin
        run_q <= '0;
      end
    end
  end

  assign level_o = filt_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
endmodule

// File: rtl/twi_slave.sv
// TWI responder giving a bus master byte access to a 256-entry register space via a simple strobe bus.
// SDA updates the cycle after a filtered SCL fall; no clock stretching, so read data must return 1 cycle after o_reg_re.
module twi_slave
  import twi_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         FILTER_LEN = 3
) (
  input  logic       i_system_clk,
  input  logic       i_system_rst,
  input  logic       i_twi_scl,
  input  logic       i_twi_sda,
  output logic       o_twi_sda,
  output logic [7:0] o_reg_addr,
  output logic [7:0] o_reg_wdata,
  output logic       o_reg_we,
  output logic       o_reg_re,
  input  logic [7:0] i_reg_rdata,
  output logic       o_busy
);
  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;
  logic start_det, stop_det;

  twi_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
    .clk_i(i_system_clk), .rst_i(i_system_rst), .line_i(i_twi_scl),
    .level_o(scl_lvl), .rise_o(scl_rise), .fall_o(scl_fall)
  );

  twi_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
    .clk_i(i_system_clk), .rst_i(i_system_rst), .line_i(i_twi_sda),
    .level_o(sda_lvl), .rise_o(sda_rise), .fall_o(sda_fall)
  );

  assign start_det = sda_fall & scl_lvl;
  assign stop_det  = sda_rise & scl_lvl;

  twi_state_e        state_q, state_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0] shift_q, shift_d;
  logic              rw_q, rw_d;
  logic              sda_q, sda_d;
  logic [7:0]        addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              re_q, re_d;
  logic              ld_q, ld_d;
  logic              busy_q, busy_d;
  logic [BYTE_W-1:0] byte_in, shift_out;

  assign byte_in   = {shift_q[BYTE_W-2:0], sda_lvl};
  assign shift_out = {shift_q[BYTE_W-2:0], 1'b0};

  always_ff @(posedge i_system_clk) begin
    if (i_system_rst) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      rw_q      <= 1'b0;
      sda_q     <= 1'b1;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      re_q      <= 1'b0;
      ld_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      rw_q      <= rw_d;
      sda_q     <= sda_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      re_q      <= re_d;
      ld_q      <= ld_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    rw_d      = rw_q;
    sda_d     = sda_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = 1'b0;
    re_d      = 1'b0;
    ld_d      = re_q;
    busy_d    = busy_q;

    // Pointer advances the cycle after a write strobe so the strobe carries the old address
    if (we_q) addr_d = addr_q + 8'd1;
    if (ld_q) shift_d = i_reg_rdata;

    if (start_det) begin
      state_d   = ST_ADDR;
      bit_cnt_d = '0;
      sda_d     = NACK;
      busy_d    = 1'b1;
    end else if (stop_det) begin
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      sda_d     = NACK;
      busy_d    = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR, ST_PTR, ST_WRITE: begin
          if (scl_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'(BYTE_W - 1)) begin
              bit_cnt_d = '0;
              if (state_q == ST_ADDR) begin
                if (byte_in[7:1] == SLAVE_ADDR) begin
                  state_d = ST_ADDR_ACK;
                  rw_d    = sda_lvl;
                end else begin
                  state_d = ST_IDLE;
                end
              end else if (state_q == ST_PTR) begin
                state_d = ST_PTR_ACK;
              end else begin
                state_d = ST_WRITE_ACK;
              end
            end
          end
        end

        // bit_cnt 0: waiting to drive ACK; 1: ACK on the bus, next fall ends the bit
        ST_ADDR_ACK, ST_PTR_ACK, ST_WRITE_ACK: begin
          if (scl_fall) begin
            if (bit_cnt_q == 4'd0) begin
              sda_d     = ACK;
              bit_cnt_d = 4'd1;
            end else begin
              sda_d     = NACK;
              bit_cnt_d = '0;
              if (state_q == ST_ADDR_ACK) begin
                if (rw_q) begin
                  state_d   = ST_READ;
                  sda_d     = shift_q[BYTE_W-1];
                  shift_d   = shift_out;
                  bit_cnt_d = 4'd1;
                end else begin
                  state_d = ST_PTR;
                end
              end else if (state_q == ST_PTR_ACK) begin
                addr_d  = shift_q;
                state_d = ST_WRITE;
              end else begin
                wdata_d = shift_q;
                we_d    = 1'b1;
                state_d = ST_WRITE;
              end
            end
          end else if (scl_rise && state_q == ST_ADDR_ACK && rw_q && bit_cnt_q == 4'd1) begin
            // Fetch during the ACK high phase so the MSB is ready for the closing fall
            re_d = 1'b1;
          end
        end

        ST_READ: begin
          if (scl_fall) begin
            if (bit_cnt_q == 4'(BYTE_W)) begin
              sda_d     = NACK;
              bit_cnt_d = '0;
              state_d   = ST_MACK;
            end else begin
              sda_d     = shift_q[BYTE_W-1];
              shift_d   = shift_out;
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end

        ST_MACK: begin
          if (scl_rise && bit_cnt_q == 4'd0) begin
            if (sda_lvl == ACK) begin
              addr_d    = addr_q + 8'd1;
              re_d      = 1'b1;
              bit_cnt_d = 4'd1;
            end else begin
              state_d = ST_IDLE;
            end
          end else if (scl_fall && bit_cnt_q == 4'd1) begin
            state_d   = ST_READ;
            sda_d     = shift_q[BYTE_W-1];
            shift_d   = shift_out;
            bit_cnt_d = 4'd1;
          end
        end

        default: ;
      endcase
    end
  end

  assign o_twi_sda   = sda_q;
  assign o_reg_addr  = addr_q;
  assign o_reg_wdata = wdata_q;
  assign o_reg_we    = we_q;
  assign o_reg_re    = re_q;
  assign o_busy      = busy_q;
endmodule

// File: tb/tb_twi_slave.sv
// Bench for twi_slave: bit-level TWI master, register-bus client memory and a byte-level reference model.
module tb_twi_slave;
  localparam int T = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  logic [7:0] rdata = 8'h00;
  logic       sda_o, we, re, busy;
  logic [7:0] reg_addr, reg_wdata;
  logic       sda_bus;

  assign sda_bus = m_sda & sda_o;

  twi_slave #(.SLAVE_ADDR(7'h50), .FILTER_LEN(3)) dut (
    .i_system_clk(clk),
    .i_system_rst(rst),
    .i_twi_scl   (m_scl),
    .i_twi_sda   (sda_bus),
    .o_twi_sda   (sda_o),
    .o_reg_addr  (reg_addr),
    .o_reg_wdata (reg_wdata),
    .o_reg_we    (we),
    .o_reg_re    (re),
    .i_reg_rdata (rdata),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  int         n_assert = 0;
  int         n_fail = 0;
  logic [7:0] cmem[256];
  logic [7:0] mmem[256];
  logic [15:0] obs_wr[$];
  logic [15:0] exp_wr[$];
  logic [7:0]  obs_re[$];
  logic [7:0]  exp_re[$];
  logic [7:0]  txq[$];
  logic        re_d1 = 1'b0;
  logic [7:0]  addr_d1 = 8'h00;
  logic        both_seen = 1'b0;
  logic        sda_low_seen = 1'b0;

  // Register-bus client: data valid exactly one cycle after the read strobe
  always @(negedge clk) begin
    rdata = re_d1 ? cmem[addr_d1] : 8'h00;
    re_d1 = re;
    addr_d1 = reg_addr;
    if (we) begin
      obs_wr.push_back({reg_addr, reg_wdata});
      cmem[reg_addr] = reg_wdata;
    end
    if (re) obs_re.push_back(reg_addr);
    if (we && re) both_seen = 1'b1;
    if (!sda_o) sda_low_seen = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_out(input logic b, input logic glitch, output logic r);
    wait_n(T);
    m_sda = b;
    if (glitch) begin
      wait_n(2); m_scl = 1'b1; wait_n(1); m_scl = 1'b0; wait_n(T - 3);
    end else begin
      wait_n(T);
    end
    m_scl = 1'b1;
    wait_n(T);
    r = sda_bus;
    wait_n(T);
    m_scl = 1'b0;
  endtask

  task automatic start_c;
    wait_n(T); m_sda = 1'b1;
    wait_n(T); m_scl = 1'b1;
    wait_n(T); m_sda = 1'b0;
    wait_n(T); m_scl = 1'b0;
  endtask

  task automatic stop_c;
    wait_n(T); m_sda = 1'b0;
    wait_n(T); m_scl = 1'b1;
    wait_n(T); m_sda = 1'b1;
    wait_n(T);
  endtask

  task automatic send_byte(input logic [7:0] b, input int glitch_bit, output logic ackd);
    logic r;
    for (int i = 7; i >= 0; i--) bit_out(b[i], i == glitch_bit, r);
    bit_out(1'b1, 1'b0, r);
    ackd = (r == 1'b0);
  endtask

  task automatic recv_byte(input logic mack, output logic [7:0] b);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bit_out(1'b1, 1'b0, r);
      b[i] = r;
    end
    bit_out(mack ? 1'b0 : 1'b1, 1'b0, r);
  endtask

  task automatic cmp_strobes(input string tag);
    chk({tag, " write-count"}, 32'(obs_wr.size()), 32'(exp_wr.size()));
    foreach (exp_wr[i]) if (i < obs_wr.size()) chk({tag, " write addr/data"}, 32'(obs_wr[i]), 32'(exp_wr[i]));
    chk({tag, " read-count"}, 32'(obs_re.size()), 32'(exp_re.size()));
    foreach (exp_re[i]) if (i < obs_re.size()) chk({tag, " read addr"}, 32'(obs_re[i]), 32'(exp_re[i]));
    obs_wr.delete(); exp_wr.delete(); obs_re.delete(); exp_re.delete();
  endtask

  // Write txq to consecutive registers from ptr; glitch_bit >= 0 adds an SCL spike in the first data byte
  task automatic wr_txn(input logic [7:0] ptr, input int glitch_bit, input string tag);
    logic a;
    start_c;
    chk({tag, " busy after START"}, 32'(busy), 32'(1));
    send_byte(8'hA0, -1, a); chk({tag, " addr ack"}, 32'(a), 32'(1));
    send_byte(ptr, -1, a);   chk({tag, " ptr ack"}, 32'(a), 32'(1));
    foreach (txq[i]) begin
      send_byte(txq[i], (i == 0) ? glitch_bit : -1, a);
      chk({tag, " data ack"}, 32'(a), 32'(1));
      exp_wr.push_back({8'(ptr + i), txq[i]});
      mmem[8'(ptr + i)] = txq[i];
    end
    stop_c;
    chk({tag, " busy after STOP"}, 32'(busy), 32'(0));
    cmp_strobes(tag);
    txq.delete();
  endtask

  task automatic rd_txn(input logic [7:0] ptr, input int n, input string tag);
    logic a;
    logic [7:0] b;
    start_c;
    send_byte(8'hA0, -1, a); chk({tag, " addr ack"}, 32'(a), 32'(1));
    send_byte(ptr, -1, a);   chk({tag, " ptr ack"}, 32'(a), 32'(1));
    start_c;
    send_byte(8'hA1, -1, a); chk({tag, " read addr ack"}, 32'(a), 32'(1));
    for (int i = 0; i < n; i++) begin
      recv_byte(i != n - 1, b);
      chk({tag, " read byte"}, 32'(b), 32'(mmem[8'(ptr + i)]));
      exp_re.push_back(8'(ptr + i));
    end
    stop_c;
    cmp_strobes(tag);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " sda"},   32'(sda_o),     32'(1));
    chk({tag, " addr"},  32'(reg_addr),  32'(0));
    chk({tag, " wdata"}, 32'(reg_wdata), 32'(0));
    chk({tag, " we"},    32'(we),        32'(0));
    chk({tag, " re"},    32'(re),        32'(0));
    chk({tag, " busy"},  32'(busy),      32'(0));
  endtask

  initial begin
    logic a;
    logic r;
    logic [7:0] p;
    int n;

    for (int i = 0; i < 256; i++) begin
      cmem[i] = 8'(i) ^ 8'hFF;
      mmem[i] = 8'(i) ^ 8'hFF;
    end

    wait_n(5);
    chk_reset_outputs("reset");
    rst = 1'b0;
    wait_n(5);

    txq = '{8'h5A, 8'hC3};
    wr_txn(8'h10, -1, "write");

    sda_low_seen = 1'b0;
    start_c;
    send_byte(8'hA2, -1, a); chk("wrong-addr addr ack", 32'(a), 32'(0));
    send_byte(8'h10, -1, a); chk("wrong-addr ptr ack", 32'(a), 32'(0));
    stop_c;
    chk("wrong-addr sda never low", 32'(sda_low_seen), 32'(0));
    chk("wrong-addr busy after STOP", 32'(busy), 32'(0));
    cmp_strobes("wrong-addr");

    rd_txn(8'h20, 3, "combined-read");

    txq = '{8'h11, 8'h22};
    wr_txn(8'hFF, -1, "wrap");
    rd_txn(8'hFF, 2, "wrap-readback");

    start_c;
    send_byte(8'hA0, -1, a); chk("abort addr ack", 32'(a), 32'(1));
    send_byte(8'h30, -1, a); chk("abort ptr ack", 32'(a), 32'(1));
    for (int i = 0; i < 4; i++) bit_out(1'b0, 1'b0, r);
    stop_c;
    chk("abort pointer loaded", 32'(reg_addr), 32'(8'h30));
    cmp_strobes("abort");
    txq = '{8'h77};
    wr_txn(8'h30, -1, "after-abort");

    txq = '{8'hA5, 8'h3C};
    wr_txn(8'h60, 3, "glitch");
    rd_txn(8'h60, 2, "glitch-readback");

    for (int k = 0; k < 6; k++) begin
      p = 8'($urandom);
      n = $urandom_range(1, 3);
      for (int i = 0; i < n; i++) txq.push_back(8'($urandom));
      wr_txn(p, -1, "rand-write");
      rd_txn(p, n, "rand-read");
    end

    txq = '{8'h3C};
    wr_txn(8'h40, -1, "pre-reset");
    start_c;
    send_byte(8'hA0, -1, a);
    send_byte(8'h40, -1, a);
    start_c;
    send_byte(8'hA1, -1, a); chk("reset-read addr ack", 32'(a), 32'(1));
    wait_n(T);
    chk("reset-read MSB driven low", 32'(sda_o), 32'(0));
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("reset releases sda next cycle", 32'(sda_o), 32'(1));
    m_scl = 1'b1;
    m_sda = 1'b1;
    wait_n(6);
    chk_reset_outputs("mid-read reset");
    exp_re.push_back(8'h40);
    cmp_strobes("mid-read reset");
    rst = 1'b0;
    wait_n(6);
    rd_txn(8'h40, 1, "post-reset");

    chk("we and re never together", 32'(both_seen), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/twi_slave.md
Name: twi_slave

Overview:
- Two-wire (I2C-style) target/responder; the counterpart of the TWI master already instantiated in the system top.
- Lets an on-board or external TWI master read and write a 256-entry byte register space inside the FPGA fabric.
- Pins use the same open-drain convention as the system top: a single output value drives both I and T of the pad buffer. 0 pulls the line low; 1 releases it.
- Sits between the IOBUF on the SDA/SCL pins and a simple synchronous register-bus client.

Parameters:
- SLAVE_ADDR, 7'h50, 7-bit device address this block responds to.
- FILTER_LEN, 3, consecutive equal synchronized samples required before a filtered SCL/SDA level changes (range 1..8).

Ports:
- i_system_clk  in  1  system clock; all logic on rising edge.
- i_system_rst  in  1  synchronous, active-high reset.
- i_twi_scl  in  1  SCL pin level, from IOBUF O (asynchronous).
- i_twi_sda  in  1  SDA pin level, from IOBUF O (asynchronous).
- o_twi_sda  out  1  SDA drive; 0 = pull low, 1 = release. Connect to both I and T of the SDA IOBUF.
- o_reg_addr  out  8  register pointer.
- o_reg_wdata  out  8  write data; valid while o_reg_we = 1.
- o_reg_we  out  1  one-cycle write strobe.
- o_reg_re  out  1  one-cycle read strobe.
- i_reg_rdata  in  8  read data; sampled exactly 1 cycle after o_reg_re.
- o_busy  out  1  1 between a START and the next STOP.

Behaviour:
- Reset values: o_twi_sda = 1, o_reg_addr = 0, o_reg_wdata = 0, o_reg_we = 0, o_reg_re = 0, o_busy = 0. FSM goes to IDLE, filters preload to 1.
- Input conditioning: 2-FF synchronizer per line, then a FILTER_LEN majority-free run filter. Edges (scl_rise, scl_fall) and START/STOP are detected on the filtered signals only.
- START: filtered SDA falls while filtered SCL = 1. STOP: filtered SDA rises while filtered SCL = 1. Either is honoured in any state and overrides bit processing in the same cycle. START (including repeated START) goes to ADDR and clears the bit counter. STOP goes to IDLE, releases SDA and clears o_busy.
- SDA is sampled on scl_rise, MSB first. o_twi_sda changes only on the cycle after scl_fall.
- FSM states:
  - IDLE: waits for START.
  - ADDR: shifts 8 bits. If bits[7:1] match SLAVE_ADDR, go to ADDR_ACK and latch R/W = bit0. Otherwise go to IDLE with SDA released until the next START.
  - ADDR_ACK: drive 0 for one SCL period. R/W = 0 goes to PTR. R/W = 1 pulses o_reg_re for the current o_reg_addr, latches i_reg_rdata into the shift register, then goes to READ.
  - PTR: shifts 8 bits, then PTR_ACK (ACK driven). At the end of the ACK bit the byte loads o_reg_addr, then go to WRITE.
  - WRITE: shifts 8 bits, then WRITE_ACK (ACK driven). At the end of the ACK bit, o_reg_wdata = byte, o_reg_we pulses 1 cycle, o_reg_addr increments, then back to WRITE.
  - READ: drives shift-register bits on each scl_fall. After bit 0 goes to MACK with SDA released.
  - MACK: samples SDA on scl_rise. 0 (ACK): o_reg_addr increments, o_reg_re pulses, next byte is latched, go to READ. 1 (NACK): go to IDLE-wait for STOP/START.
- o_reg_addr wraps 8'hFF -> 8'h00 on increment.
- o_reg_we and o_reg_re never assert in the same cycle. Neither asserts outside a matched transaction.
- Clock stretching is not supported. The bus client must return data 1 cycle after o_reg_re.
- A START or STOP in the middle of a byte discards the partial byte; no strobe is issued.
- Reset asserted mid-transfer releases SDA in the same cycle that reset is registered.

Decomposition:
- Package twi_pkg holds:
  - the FSM state enum;
  - constants for ACK = 1'b0 and NACK = 1'b1;
  - BYTE_W = 8.
- One sub-module, twi_line_filter: synchronizer, run filter, rise/fall outputs. It is instantiated twice, once for SCL and once for SDA.

Test Plan:
- Write, addr 0x50: START, 0xA0, 0x10, 0x5A, 0xC3, STOP -> ACK on all four bytes; o_reg_we pulses with (addr 0x10, data 0x5A) then (0x11, 0xC3); o_busy = 0 after STOP.
- Wrong address: START, 0xA2, 0x10, STOP -> SDA never driven low; no strobes.
- Combined read: START, 0xA0, 0x20, repeated START, 0xA1, read 3 bytes (ACK, ACK, NACK), STOP, with rdata = addr ^ 0xFF -> master receives 0xDF, 0xDE, 0xDD; o_reg_re pulses at 0x20, 0x21, 0x22.
- Wrap: pointer 0xFF, write 2 bytes -> strobes at addresses 0xFF then 0x00.
- Abort: STOP after 4 bits of a data byte -> no o_reg_we; next transaction acks normally.
- Glitch: 1-cycle SCL pulse with FILTER_LEN = 3 -> no bit shifted. Reset asserted during a read bit driving 0 -> o_twi_sda = 1 on the next cycle.
